pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready handshake,
//  2-entry skid buffer, synchronous flush and bubble-safe control gating. Replaces the fixed-width,
//  always-advancing stage registers. Sits between two pipeline stages and lets hazard logic stall and kill.
// PARAMETERS
//  DATA_W    32  width of one data lane (alu_result, busB, PC, ...)
//  NUM_DATA  2   number of data lanes carried; in_data/out_data = NUM_DATA*DATA_W bits, lane 0 in LSBs
//  RW_W      5   destination register index width
//  CTRL_W    4   control-bit vector width (default bit order: {MemtoReg,MemWr,RegWr,Zero}, bit0=Zero)
//  STAT_W    16  width of statistics counters (PIPE_STATS_EN only)
// PORTS
//  Clk        in   1                  rising-edge clock
//  Rst_n      in   1                  synchronous reset, active low
//  flush      in   1                  kill all held entries (branch taken / exception)
//  in_valid   in   1                  upstream presents an entry
//  in_ready   out  1                  register can accept; registered, not combinational from out_ready
//  in_data    in   NUM_DATA*DATA_W    data lanes
//  in_Rw      in   RW_W               destination register
//  in_ctrl    in   CTRL_W             control bits
//  out_valid  out  1                  head entry valid
//  out_ready  in   1                  downstream consumes head entry
//  out_data   out  NUM_DATA*DATA_W    head data
//  out_Rw     out  RW_W               head destination register
//  out_ctrl   out  CTRL_W             head control; forced 0 when out_valid=0
//  stall_cnt  out  STAT_W             cycles with out_valid=1 && out_ready=0 (PIPE_STATS_EN only)
//  bubble_cnt out  STAT_W             cycles with out_valid=0 (PIPE_STATS_EN only)
// BEHAVIOUR
//  - One clock (Clk); reset is synchronous, active-low on Rst_n: at posedge Clk with Rst_n=0 all state clears.
//  - Reset values: out_valid=0, in_ready=1, out_data=0, out_Rw=0, out_ctrl=0, counters=0; state EMPTY.
//  - Fire: in_fire = in_valid&in_ready; out_fire = out_valid&out_ready.
//  - Storage: main slot (drives outputs), skid slot. FSM: EMPTY, ONE (main), FULL (main+skid).
//    EMPTY: in_fire -> main, ONE.  else EMPTY.
//    ONE:   in_fire&out_fire -> main<=in, ONE; in_fire only -> skid<=in, FULL; out_fire only -> EMPTY.
//    FULL:  in_ready=0; out_fire -> main<=skid, ONE; else hold FULL.
//  - in_ready = (next state != FULL), registered. Latency EMPTY->out_valid: 1 cycle. Throughput 1/cycle.
//  - Holds are lossless: data stable while out_valid=1 && out_ready=0.
//  - flush=1 at an edge: state -> EMPTY, out_valid=0, in_ready=1 next cycle; same-cycle in_fire is dropped;
//    flush has priority over every transition; out_fire in that cycle still counts as consumed.
//  - Rst_n=0 mid-transfer: same as flush plus data/Rw cleared; reset outranks flush.
//  - out_ctrl gated to 0 whenever out_valid=0, so RegWr/MemWr never assert on a bubble.
//  - No arithmetic on the datapath; lanes pass unmodified bit-for-bit.
// CONFIGURATION
//  - Macro PIPE_STATS_EN: defined -> stall_cnt/bubble_cnt ports exist, increment once per qualifying cycle,
//    saturate at 2^STAT_W-1, clear on reset only (not on flush).
//    Not defined -> ports absent, no counter logic; all other behaviour identical.
// STRUCTURE
//  - Package pipe_pkg: state enum {EMPTY,ONE,FULL}, default widths (DATA_W=32, RW_W=5), CTRL bit index
//    constants (CTRL_ZERO=0, CTRL_REGWR=1, CTRL_MEMWR=2, CTRL_MEMTOREG=3).
//  - One sub-module: sat_counter (STAT_W, inc, Clk, Rst_n -> count), instantiated twice under PIPE_STATS_EN.
// TESTING
//  1 Reset: Rst_n=0 two cycles with in_valid=1, in_ctrl=4'hF -> out_valid=0, out_ctrl=0, in_ready=1 after.
//  2 Streaming: out_ready=1, push 8 entries alu=i, busB=~i, Rw=i -> each emerges 1 cycle later, no gaps.
//  3 Stall/skid: ONE, out_ready=0, push A then B -> FULL, in_ready=0; out_ready=1 -> A then B, no loss.
//  4 Flush in FULL with in_valid=1 (C) -> next cycle out_valid=0, in_ready=1; C never appears.
//  5 Bubble gating: in_ctrl=4'b0110 entry consumed, no new input -> out_ctrl=0 while out_valid=0.
//  6 PIPE_STATS_EN, STAT_W=4: hold out_valid=1,out_ready=0 for 20 cycles -> stall_cnt=15 (saturated).

Source files
------------

// File: rtl/pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : pipe_pkg                                                        |
// | Desc     : Shared state encoding, default widths and control bit indices.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RW_W   = 5;

  localparam int CTRL_ZERO     = 0;
  localparam int CTRL_REGWR    = 1;
  localparam int CTRL_MEMWR    = 2;
  localparam int CTRL_MEMTOREG = 3;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
// +----------------------------------------------------------------------------+
// | Module   : sat_counter                                                     |
// | Desc     : Saturating up-counter, cleared only by synchronous reset.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int STAT_W = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  logic [STAT_W-1:0] r_count;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {STAT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule : sat_counter

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// +----------------------------------------------------------------------------+
// | Module   : pipe_stage_reg                                                  |
// | Desc     : Inter-stage pipeline register, valid/ready with 2-entry skid,   |
// |            flush and bubble-gated control. Macro PIPE_STATS_EN adds        |
// |            saturating stall/bubble counters.                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_DATA = 2,
  parameter int RW_W     = DEF_RW_W,
  parameter int CTRL_W   = 4
`ifdef PIPE_STATS_EN
  ,
  parameter int STAT_W   = 16
`endif
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [RW_W-1:0]            in_Rw,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [RW_W-1:0]            out_Rw,
`ifdef PIPE_STATS_EN
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [STAT_W-1:0]          stall_cnt,
  output logic [STAT_W-1:0]          bubble_cnt
`else
  output logic [CTRL_W-1:0]          out_ctrl
`endif
);

  localparam int c_LANES_W = NUM_DATA * DATA_W;

  pipe_state_e r_state, w_state_nxt;

  logic [c_LANES_W-1:0] r_main_data, r_skid_data, w_main_data_nxt, w_skid_data_nxt;
  logic [RW_W-1:0]      r_main_rw,   r_skid_rw,   w_main_rw_nxt,   w_skid_rw_nxt;
  logic [CTRL_W-1:0]    r_main_ctrl, r_skid_ctrl, w_main_ctrl_nxt, w_skid_ctrl_nxt;
  logic                 r_in_ready;
  logic                 w_in_fire, w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_rw_nxt   = r_main_rw;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_rw_nxt   = r_skid_rw;
    w_skid_ctrl_nxt = r_skid_ctrl;

    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_main_data_nxt = in_data;
          w_main_rw_nxt   = in_Rw;
          w_main_ctrl_nxt = in_ctrl;
          w_state_nxt     = ONE;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_data_nxt = in_data;
          w_main_rw_nxt   = in_Rw;
          w_main_ctrl_nxt = in_ctrl;
        end else if (w_in_fire) begin
          w_skid_data_nxt = in_data;
          w_skid_rw_nxt   = in_Rw;
          w_skid_ctrl_nxt = in_ctrl;
          w_state_nxt     = FULL;
        end else if (w_out_fire) begin
          w_state_nxt     = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_main_data_nxt = r_skid_data;
          w_main_rw_nxt   = r_skid_rw;
          w_main_ctrl_nxt = r_skid_ctrl;
          w_state_nxt     = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase

    // Flush kills everything held; any entry accepted this cycle is lost too.
    if (flush) begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_main_data <= '0;
      r_main_rw   <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_rw   <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_main_data <= w_main_data_nxt;
      r_main_rw   <= w_main_rw_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_rw   <= w_skid_rw_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main_data;
  assign out_Rw    = r_main_rw;
  // Bubbles must never carry RegWr/MemWr into the next stage.
  assign out_ctrl  = out_valid ? r_main_ctrl : '0;

`ifdef PIPE_STATS_EN
  sat_counter #(.STAT_W(STAT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.STAT_W(STAT_W)) u_bubble_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (~out_valid),
    .count (bubble_cnt)
  );
`endif

endmodule : pipe_stage_reg

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_stage_reg                                               |
// | Desc     : Directed self-checking bench for pipe_stage_reg.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [4:0]  in_Rw, out_Rw;
  logic [3:0]  in_ctrl, out_ctrl;
`ifdef PIPE_STATS_EN
  logic [3:0]  stall_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

`ifdef PIPE_STATS_EN
  pipe_stage_reg #(.STAT_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_Rw(in_Rw), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_Rw(out_Rw),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );
`else
  pipe_stage_reg dut (
    .Clk(Clk), .Rst_n(Rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_Rw(in_Rw), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_Rw(out_Rw),
    .out_ctrl(out_ctrl)
  );
`endif

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [63:0] lanes(input logic [31:0] v);
    return {~v, v};
  endfunction

  task automatic push(input logic [31:0] v, input logic [3:0] c);
    in_valid = 1'b1;
    in_data  = lanes(v);
    in_Rw    = v[4:0];
    in_ctrl  = c;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = '1; in_Rw = '1; in_ctrl = 4'hF;
    tick(); tick();
    Rst_n = 1'b1; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_ctrl !== 4'h0) begin errors++; $display("FAIL reset_out_ctrl got %h exp 0", out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(32'(i), 4'(i));
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== lanes(32'(i)) || out_Rw !== 5'(i) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d got v=%b d=%h rw=%0d rdy=%b exp v=1 d=%h rw=%0d rdy=1",
                 i, out_valid, out_data, out_Rw, in_ready, lanes(32'(i)), i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    push(32'hA, 4'h1); tick();
    push(32'hB, 4'h2); tick();
    checks++; if (in_ready !== 1'b0 || out_data !== lanes(32'hA)) begin
      errors++; $display("FAIL skid_full got rdy=%b d=%h exp rdy=0 d=%h", in_ready, out_data, lanes(32'hA)); end
    push(32'hC, 4'h3); tick();
    checks++; if (out_valid !== 1'b1 || out_data !== lanes(32'hA) || out_ctrl !== 4'h1) begin
      errors++; $display("FAIL skid_hold got v=%b d=%h c=%h exp v=1 d=%h c=1", out_valid, out_data, out_ctrl, lanes(32'hA)); end
    in_valid = 1'b0; out_ready = 1'b1; tick();
    checks++; if (out_valid !== 1'b1 || out_data !== lanes(32'hB) || out_Rw !== 5'hB || in_ready !== 1'b1) begin
      errors++; $display("FAIL skid_second got v=%b d=%h rw=%h rdy=%b exp v=1 d=%h rw=0b rdy=1",
                         out_valid, out_data, out_Rw, in_ready, lanes(32'hB)); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(32'hD, 4'h4); tick();
    push(32'hE, 4'h5); tick();
    push(32'hC, 4'h6); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    out_ready = 1'b1; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got v=%b d=%h exp v=0", out_valid, out_data); end
    // Flush in ONE with a same-cycle accepted entry: that entry is dropped.
    out_ready = 1'b0;
    push(32'h11, 4'h7); tick();
    push(32'h22, 4'h7); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_drop_in got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    push(32'h5, 4'b0110); tick();
    in_valid = 1'b0;
    checks++; if (out_ctrl !== 4'b0110 || out_ctrl[CTRL_REGWR] !== 1'b1) begin
      errors++; $display("FAIL bubble_live got %b exp 0110", out_ctrl); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'b0000) begin
      errors++; $display("FAIL bubble_gate got v=%b c=%b exp v=0 c=0000", out_valid, out_ctrl); end
    tick();
    checks++; if (out_ctrl[CTRL_MEMWR] !== 1'b0 || out_ctrl[CTRL_REGWR] !== 1'b0) begin
      errors++; $display("FAIL bubble_gate2 got c=%b exp 0000", out_ctrl); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    push(32'h33, 4'h9); tick();
    push(32'h44, 4'h9); tick();
    in_valid = 1'b0; Rst_n = 1'b0; flush = 1'b1; tick();
    Rst_n = 1'b1; flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'h0 || out_Rw !== 5'h0) begin
      errors++; $display("FAIL reset_mid got v=%b rdy=%b d=%h rw=%h exp v=0 rdy=1 d=0 rw=0",
                         out_valid, in_ready, out_data, out_Rw); end
  endtask

`ifdef PIPE_STATS_EN
  task automatic test_stats();
    Rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; tick();
    Rst_n = 1'b1;
    checks++; if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
      errors++; $display("FAIL stats_reset got s=%0d b=%0d exp 0 0", stall_cnt, bubble_cnt); end
    tick(); tick(); tick();
    push(32'h77, 4'h1); tick();
    in_valid = 1'b0;
    checks++; if (bubble_cnt !== 4'd4) begin errors++; $display("FAIL stats_bubble got %0d exp 4", bubble_cnt); end
    for (int i = 0; i < 20; i++) tick();
    checks++; if (stall_cnt !== 4'd15 || bubble_cnt !== 4'd4) begin
      errors++; $display("FAIL stats_stall_sat got s=%0d b=%0d exp 15 4", stall_cnt, bubble_cnt); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL stats_flush_keep got %0d exp 15", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_bubble();
    test_reset_mid();
`ifdef PIPE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_reg

`default_nettype wire
